// File: rtl/gpio_exp_pkg.sv
// Shared constants, frame layout and FSM encoding for the SPI GPIO expander.
package gpio_exp_pkg;

    localparam int FRAME_WIDTH = 16;
    localparam int PDATA_WIDTH = 8;

    // Field positions within the 16-bit frame (MSB first on the wire)
    localparam int FRAME_RW_BIT   = 15;
    localparam int FRAME_BANK_LSB = 13;
    localparam int FRAME_ADDR_LSB = 10;
    localparam int BANK_W         = 2;
    localparam int ADDR_W         = 3;

    // Same fields, expressed as positions within the header byte (frame bits 15..8)
    localparam int HDR_RW_BIT   = FRAME_RW_BIT - PDATA_WIDTH;
    localparam int HDR_BANK_LSB = FRAME_BANK_LSB - PDATA_WIDTH;
    localparam int HDR_ADDR_LSB = FRAME_ADDR_LSB - PDATA_WIDTH;

    // Per-bank register addresses
    localparam logic [ADDR_W-1:0] ADDR_DIR      = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_OUT      = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IN       = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_STAT = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_EDGE     = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } spi_state_t;

endpackage

// File: rtl/gpio_exp_bank.sv
// One 8-bit GPIO bank: config registers, pad tri-state, pad synchroniser,
// edge-detect interrupt status and the bank's contribution to irq.
module gpio_exp_bank
    import gpio_exp_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [PDATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [PDATA_WIDTH-1:0] rd_data,
    output logic                   irq_term,
    inout  wire  [PDATA_WIDTH-1:0] pad
);

    logic [PDATA_WIDTH-1:0] dir_q;
    logic [PDATA_WIDTH-1:0] out_q;
    logic [PDATA_WIDTH-1:0] en_q;
    logic [PDATA_WIDTH-1:0] stat_q;
    logic [PDATA_WIDTH-1:0] edge_q;

    logic [PDATA_WIDTH-1:0] pad_sync [SYNC_STAGES];
    logic [PDATA_WIDTH-1:0] pad_prev;
    logic [PDATA_WIDTH-1:0] pad_in;
    logic [PDATA_WIDTH-1:0] edge_hit;
    logic [PDATA_WIDTH-1:0] stat_set;
    logic [PDATA_WIDTH-1:0] stat_clr;

    // Each pad is driven with OUT only when its DIR bit selects output
    for (genvar i = 0; i < PDATA_WIDTH; i++) begin : g_pad
        assign pad[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    // Synchronise the pad inputs and keep a one-cycle-delayed copy for edge detect
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                pad_sync[i] <= '0;
            end
            pad_prev <= '0;
        end else begin
            pad_sync[0] <= pad;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pad_sync[i] <= pad_sync[i-1];
            end
            pad_prev <= pad_sync[SYNC_STAGES-1];
        end
    end

    assign pad_in   = pad_sync[SYNC_STAGES-1];
    assign edge_hit = (edge_q & ~pad_in & pad_prev) | (~edge_q & pad_in & ~pad_prev);
    assign stat_set = edge_hit & ~dir_q;
    assign stat_clr = (wr_en && (wr_addr == ADDR_IRQ_STAT)) ? wr_data : '0;

    // Host writes to the config registers; status clears by W1C but a new edge wins
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dir_q  <= '0;
            out_q  <= '0;
            en_q   <= '0;
            edge_q <= '0;
            stat_q <= '0;
        end else begin
            if (wr_en) begin
                case (wr_addr)
                    ADDR_DIR:    dir_q  <= wr_data;
                    ADDR_OUT:    out_q  <= wr_data;
                    ADDR_IRQ_EN: en_q   <= wr_data;
                    ADDR_EDGE:   edge_q <= wr_data;
                    default:     ;
                endcase
            end
            stat_q <= (stat_q & ~stat_clr) | stat_set;
        end
    end

    // Register read mux; IN reflects the synchronised pad, reserved slots read 0
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_DIR:      rd_data = dir_q;
            ADDR_OUT:      rd_data = out_q;
            ADDR_IN:       rd_data = pad_in;
            ADDR_IRQ_EN:   rd_data = en_q;
            ADDR_IRQ_STAT: rd_data = stat_q;
            ADDR_EDGE:     rd_data = edge_q;
            default:       rd_data = '0;
        endcase
    end

    assign irq_term = |(stat_q & en_q);

endmodule

// File: rtl/gpio_expander_irq.sv
// SPI mode-0 slave front-end (oversampled on clk) plus BANK_NUM GPIO banks
// with edge interrupts and a registered combined irq output.
module gpio_expander_irq
    import gpio_exp_pkg::*;
#(
    parameter int BANK_NUM    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            sclk,
    input  logic                            ss,
    input  logic                            mosi,
    output logic                            miso,
    output logic                            irq,
    inout  wire  [BANK_NUM*PDATA_WIDTH-1:0] pad
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   ss_d;
    logic                   sclk_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   ss_fall;
    logic                   ss_rise;

    spi_state_t             state;
    logic [4:0]             bit_cnt;
    logic [6:0]             rx_shift;
    logic [PDATA_WIDTH-1:0] rx_next;
    logic [PDATA_WIDTH-1:0] tx_shift;
    logic                   miso_q;
    logic                   hdr_rw;
    logic [BANK_W-1:0]      hdr_bank;
    logic [ADDR_W-1:0]      hdr_addr;
    logic                   wr_stb;
    logic [PDATA_WIDTH-1:0] wr_data;

    logic [BANK_W-1:0]      cur_bank;
    logic [ADDR_W-1:0]      cur_addr;
    logic [PDATA_WIDTH-1:0] sel_rd;
    logic                   unused_rsvd;

    logic [PDATA_WIDTH-1:0] bank_rd [BANK_NUM];
    logic [BANK_NUM-1:0]    bank_irq;

    // Bring the SPI pins into the clk domain and remember last sclk/ss for edge detect
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_fall   = ~ss_s & ss_d;
    assign ss_rise   = ss_s & ~ss_d;

    // The byte as it will look after this rising edge; holds the header on the 8th
    // edge and the write data on the 16th
    assign rx_next     = {rx_shift, mosi_s};
    assign cur_bank    = rx_next[HDR_BANK_LSB +: BANK_W];
    assign cur_addr    = rx_next[HDR_ADDR_LSB +: ADDR_W];
    assign unused_rsvd = ^rx_next[HDR_ADDR_LSB-1:0];

    // Select the addressed bank's read data; banks beyond BANK_NUM read as 0
    always_comb begin
        sel_rd = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (cur_bank == BANK_W'(b)) begin
                sel_rd = bank_rd[b];
            end
        end
    end

    // Frame FSM: header, data, then wait for ss; ss rising mid-frame aborts
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            miso_q   <= 1'b0;
            hdr_rw   <= 1'b0;
            hdr_bank <= '0;
            hdr_addr <= '0;
            wr_stb   <= 1'b0;
            wr_data  <= '0;
        end else begin
            wr_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state    <= HDR;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        tx_shift <= '0;
                        miso_q   <= 1'b0;
                    end
                end
                HDR: begin
                    if (ss_rise) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next[6:0];
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            hdr_rw   <= rx_next[HDR_RW_BIT];
                            hdr_bank <= cur_bank;
                            hdr_addr <= cur_addr;
                            tx_shift <= rx_next[HDR_RW_BIT] ? '0 : sel_rd;
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (ss_rise) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        miso_q  <= 1'b0;
                    end else if (sclk_rise) begin
                        rx_shift <= rx_next[6:0];
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            state <= DONE;
                            if (hdr_rw) begin
                                wr_stb  <= 1'b1;
                                wr_data <= rx_next;
                            end
                        end
                    end else if (sclk_fall) begin
                        miso_q   <= tx_shift[PDATA_WIDTH-1];
                        tx_shift <= {tx_shift[PDATA_WIDTH-2:0], 1'b0};
                    end
                end
                DONE: begin
                    miso_q <= 1'b0;
                    if (ss_rise) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign miso = (!ss && (state != IDLE)) ? miso_q : 1'bz;

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        gpio_exp_bank #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_bank (
            .clk      (clk),
            .resetn   (resetn),
            .wr_en    (wr_stb && (hdr_bank == BANK_W'(b))),
            .wr_addr  (hdr_addr),
            .wr_data  (wr_data),
            .rd_addr  (cur_addr),
            .rd_data  (bank_rd[b]),
            .irq_term (bank_irq[b]),
            .pad      (pad[b*PDATA_WIDTH +: PDATA_WIDTH])
        );
    end

    // Combined interrupt, registered so it follows status/enable by one clk
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq <= 1'b0;
        end else begin
            irq <= |bank_irq;
        end
    end

endmodule

// File: tb/tb_gpio_expander_irq.sv
// Scoreboard bench for gpio_expander_irq: read frames push their expected byte,
// a monitor pops and compares each byte the SPI master collects from miso.
module tb_gpio_expander_irq;

    localparam int BANK_NUM    = 2;
    localparam int SYNC_STAGES = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sclk;
    logic        ss;
    logic        mosi;
    wire         miso;
    logic        irq;
    wire  [15:0] pad;

    logic [15:0] tb_pad_en;
    logic [15:0] tb_pad_val;

    int          tests_run    = 0;
    int          tests_failed = 0;

    logic [7:0]  exp_q [$];
    string       name_q [$];
    logic [7:0]  read_byte;
    event        read_done;

    gpio_expander_irq #(
        .BANK_NUM    (BANK_NUM),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .sclk   (sclk),
        .ss     (ss),
        .mosi   (mosi),
        .miso   (miso),
        .irq    (irq),
        .pad    (pad)
    );

    for (genvar i = 0; i < 16; i++) begin : g_drv
        assign pad[i] = tb_pad_en[i] ? tb_pad_val[i] : 1'bz;
    end

    always #5 clk = ~clk;

    // Single comparison point shared by immediate checks and the monitor
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk_frame(input logic rw, input logic [1:0] bank,
                                             input logic [2:0] addr, input logic [7:0] data);
        return {rw, bank, addr, 2'b00, data};
    endfunction

    // Mode-0 SPI master, 16 clk per sclk period; optional early abort, ss left low,
    // or a pad[0] rise a given number of clks after the last rising sclk
    task automatic spi_xfer(input logic [15:0] frame, input int nbits, input int pad0_hook,
                            input bit keep_ss, output logic [7:0] rd);
        rd = '0;
        @(negedge clk);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = frame[15-i];
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            if (i >= 8) rd[15-i] = miso;
            if (i == nbits - 1 && pad0_hook >= 0) begin
                repeat (pad0_hook) @(negedge clk);
                tb_pad_val[0] = 1'b1;
                repeat (8 - pad0_hook) @(negedge clk);
            end else begin
                repeat (8) @(negedge clk);
            end
            sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        if (!keep_ss) ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [1:0] bank, input logic [2:0] addr, input logic [7:0] data);
        logic [7:0] rd;
        spi_xfer(mk_frame(1'b1, bank, addr, data), 16, -1, 1'b0, rd);
    endtask

    // Issue a read frame, pushing its expected byte before the transfer starts
    task automatic read_expect(input logic [1:0] bank, input logic [2:0] addr,
                               input logic [7:0] exp, input string name);
        logic [7:0] rd;
        exp_q.push_back(exp);
        name_q.push_back(name);
        spi_xfer(mk_frame(1'b0, bank, addr, 8'h00), 16, -1, 1'b0, rd);
        read_byte = rd;
        -> read_done;
    endtask

    // Monitor: every byte seen on miso is matched against the oldest expectation
    initial begin
        forever begin
            @(read_done);
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected read: got 0x%0h, expected no read", read_byte);
            end else begin
                check_output(name_q.pop_front(), {24'h0, read_byte}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Hang guard
    initial begin
        repeat (60000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit seen;
        resetn     = 1'b0;
        sclk       = 1'b0;
        ss         = 1'b1;
        mosi       = 1'b0;
        tb_pad_en  = '0;
        tb_pad_val = '0;
        repeat (5) @(negedge clk);
        check_output("irq in reset", {31'h0, irq}, 32'h0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Reset values
        read_expect(2'd0, 3'd0, 8'h00, "reset DIR0");
        read_expect(2'd1, 3'd3, 8'h00, "reset IRQ_EN1");

        // Bank1 outputs
        apply_stimulus(2'd1, 3'd0, 8'hFF);
        apply_stimulus(2'd1, 3'd1, 8'hA5);
        repeat (4) @(negedge clk);
        check_output("pad bank1 drive", {24'h0, pad[15:8]}, 32'hA5);
        read_expect(2'd1, 3'd1, 8'hA5, "read OUT1");
        read_expect(2'd1, 3'd0, 8'hFF, "read DIR1");

        // Inputs, out-of-range bank, reserved addresses
        tb_pad_en[7:0]  = 8'hFF;
        tb_pad_val[7:0] = 8'h3C;
        repeat (6) @(negedge clk);
        read_expect(2'd0, 3'd2, 8'h3C, "read IN0");
        read_expect(2'd3, 3'd2, 8'h00, "read bank3 IN");
        read_expect(2'd1, 3'd2, 8'hA5, "read IN1 of driven pads");
        apply_stimulus(2'd0, 3'd6, 8'h55);
        read_expect(2'd0, 3'd6, 8'h00, "reserved addr6");
        apply_stimulus(2'd3, 3'd1, 8'h77);
        read_expect(2'd1, 3'd1, 8'hA5, "bank3 write ignored");

        // Rising-edge interrupt on pad[0]
        tb_pad_val[7:0] = 8'h00;
        repeat (6) @(negedge clk);
        apply_stimulus(2'd0, 3'd4, 8'hFF);
        apply_stimulus(2'd0, 3'd3, 8'h01);
        apply_stimulus(2'd0, 3'd5, 8'h00);
        check_output("irq idle", {31'h0, irq}, 32'h0);
        @(negedge clk);
        tb_pad_val[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < SYNC_STAGES + 2; k++) begin
            @(posedge clk);
            #1;
            if (irq) begin
                seen = 1'b1;
                break;
            end
        end
        check_output("irq rise latency", {31'h0, seen}, 32'h1);
        read_expect(2'd0, 3'd4, 8'h01, "stat after rise");
        apply_stimulus(2'd0, 3'd4, 8'h01);
        check_output("irq after W1C", {31'h0, irq}, 32'h0);
        read_expect(2'd0, 3'd4, 8'h00, "stat after W1C");
        tb_pad_val[0] = 1'b0;
        repeat (8) @(negedge clk);
        read_expect(2'd0, 3'd4, 8'h00, "falling edge ignored");
        check_output("irq after falling", {31'h0, irq}, 32'h0);

        // Status latches while disabled; enabling later raises irq
        apply_stimulus(2'd0, 3'd3, 8'h00);
        tb_pad_val[1] = 1'b1;
        repeat (8) @(negedge clk);
        check_output("irq masked", {31'h0, irq}, 32'h0);
        read_expect(2'd0, 3'd4, 8'h02, "stat latched masked");
        apply_stimulus(2'd0, 3'd3, 8'h02);
        check_output("irq late enable", {31'h0, irq}, 32'h1);
        apply_stimulus(2'd0, 3'd4, 8'h02);
        check_output("irq cleared bit1", {31'h0, irq}, 32'h0);

        // Falling-edge select on pad[3]
        apply_stimulus(2'd0, 3'd5, 8'h08);
        tb_pad_val[3] = 1'b1;
        repeat (8) @(negedge clk);
        read_expect(2'd0, 3'd4, 8'h00, "edge sel ignores rise");
        tb_pad_val[3] = 1'b0;
        repeat (8) @(negedge clk);
        read_expect(2'd0, 3'd4, 8'h08, "edge sel falling");
        apply_stimulus(2'd0, 3'd4, 8'h08);

        // Output-direction bit never sets status
        tb_pad_en[4] = 1'b0;
        apply_stimulus(2'd0, 3'd0, 8'h10);
        apply_stimulus(2'd0, 3'd1, 8'h10);
        repeat (8) @(negedge clk);
        read_expect(2'd0, 3'd4, 8'h00, "output bit no status");
        apply_stimulus(2'd0, 3'd0, 8'h00);
        tb_pad_en[4] = 1'b1;
        repeat (8) @(negedge clk);

        // Aborted write after 11 rising edges
        begin
            logic [7:0] rd;
            spi_xfer(mk_frame(1'b1, 2'd0, 3'd1, 8'hFF), 11, -1, 1'b0, rd);
        end
        read_expect(2'd0, 3'd1, 8'h10, "OUT0 after abort");
        apply_stimulus(2'd0, 3'd1, 8'h12);
        read_expect(2'd0, 3'd1, 8'h12, "frame after abort");

        // Edge set in the same clk as a W1C of the same bit
        begin
            logic [7:0] rd;
            spi_xfer(mk_frame(1'b1, 2'd0, 3'd4, 8'h01), 16, 1, 1'b0, rd);
        end
        read_expect(2'd0, 3'd4, 8'h01, "set wins over W1C");

        // Mid-frame reset with bank1 driving 0xFF
        apply_stimulus(2'd1, 3'd1, 8'hFF);
        apply_stimulus(2'd0, 3'd3, 8'h01);
        check_output("pad bank1 0xFF", {24'h0, pad[15:8]}, 32'hFF);
        check_output("irq before reset", {31'h0, irq}, 32'h1);
        begin
            logic [7:0] rd;
            spi_xfer(mk_frame(1'b1, 2'd1, 3'd1, 8'h00), 6, -1, 1'b1, rd);
        end
        resetn = 1'b0;
        ss     = 1'b1;
        sclk   = 1'b0;
        mosi   = 1'b0;
        #1;
        check_output("irq async reset", {31'h0, irq}, 32'h0);
        tb_pad_en[15:8]  = 8'hFF;
        tb_pad_val[15:8] = 8'h5A;
        repeat (3) @(negedge clk);
        check_output("pad bank1 released", {24'h0, pad[15:8]}, 32'h5A);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check_output("irq after reset", {31'h0, irq}, 32'h0);
        read_expect(2'd1, 3'd2, 8'h5A, "first frame after reset");
        read_expect(2'd1, 3'd0, 8'h00, "DIR1 after reset");
        apply_stimulus(2'd1, 3'd1, 8'h33);
        read_expect(2'd1, 3'd1, 8'h33, "write after reset");

        repeat (20) @(negedge clk);
        check_output("scoreboard drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
